// File: rtl/draw_sprite_if.sv
// Pixel/ROM/handshake bundle between a draw_sprite blitter (slave side) and its
// requester, ROM and VGA adapter (master side).
interface draw_sprite_if #(
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 7,
    parameter int COLOR_BITS = 3,
    parameter int ADDR_BITS  = 15
);
    logic                  begin_draw;
    logic [X_BITS-1:0]     x0;
    logic [Y_BITS-1:0]     y0;
    logic [ADDR_BITS-1:0]  rom_addr;
    logic [COLOR_BITS-1:0] rom_data;
    logic [X_BITS-1:0]     x;
    logic [Y_BITS-1:0]     y;
    logic [COLOR_BITS-1:0] color;
    logic                  drawEn;
    logic                  busy;
    logic                  done;

    modport master (
        output begin_draw, x0, y0, rom_data,
        input  rom_addr, x, y, color, drawEn, busy, done
    );

    modport slave (
        input  begin_draw, x0, y0, rom_data,
        output rom_addr, x, y, color, drawEn, busy, done
    );
endinterface

// File: rtl/draw_sprite.sv
// W x H ROM image blitter at runtime origin, clipped to screen; one pixel per ROM_LATENCY+2 cycles,
// level begin_draw/done handshake (no backpressure). DRAW_SPRITE_TRANSPARENT_EN skips KEY_COLOR pixels.
module draw_sprite #(
    parameter int W           = 160,
    parameter int H           = 120,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOR_BITS  = 3,
    parameter int ADDR_BITS   = 15,
    parameter int BASE_ADDR   = 0,
    parameter int ROM_LATENCY = 1,
    parameter logic [COLOR_BITS-1:0] KEY_COLOR = '0
) (
    input  logic         clk,
    input  logic         reset,
    draw_sprite_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    localparam int RW = $clog2(H + 1);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, PLOT, DONE} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [X_BITS-1:0]    x0_q;
    logic [Y_BITS-1:0]    y0_q;
    logic [ADDR_BITS-1:0] addr_ptr;
    logic [2:0]           wcnt;
    logic                 last_col, last_pix, wait_end;
    logic [X_BITS:0]      x_sum;
    logic [Y_BITS:0]      y_sum;
    logic                 clipped, skip;

    assign last_col = (col == CW'(W - 1));
    assign last_pix = last_col && (row == RW'(H - 1));
    assign wait_end = (wcnt == 3'(ROM_LATENCY - 1));

    // One extra bit so a wrap past the coordinate width still reads as off-screen.
    assign x_sum   = {1'b0, x0_q} + (X_BITS+1)'(col);
    assign y_sum   = {1'b0, y0_q} + (Y_BITS+1)'(row);
    assign clipped = (x_sum >= (X_BITS+1)'(SCREEN_W)) || (y_sum >= (Y_BITS+1)'(SCREEN_H));

`ifdef DRAW_SPRITE_TRANSPARENT_EN
    assign skip = clipped || (bus.rom_data == KEY_COLOR);
`else
    logic unused_key;
    assign unused_key = ^KEY_COLOR;
    assign skip       = clipped;
`endif

    assign bus.busy = (state == ADDR) || (state == WAIT) || (state == PLOT);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.begin_draw) state_next = ADDR;
            ADDR:    state_next = WAIT;
            WAIT:    if (wait_end) state_next = PLOT;
            PLOT:    state_next = last_pix ? DONE : ADDR;
            DONE:    if (bus.done && !bus.begin_draw) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rom_addr <= ADDR_BITS'(BASE_ADDR);
            bus.x        <= '0;
            bus.y        <= '0;
            bus.color    <= '0;
            bus.drawEn   <= 1'b0;
            bus.done     <= 1'b0;
            col          <= '0;
            row          <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            addr_ptr     <= ADDR_BITS'(BASE_ADDR);
            wcnt         <= '0;
        end else begin
            bus.drawEn <= 1'b0;
            case (state)
                IDLE: if (bus.begin_draw) begin
                    x0_q     <= bus.x0;
                    y0_q     <= bus.y0;
                    col      <= '0;
                    row      <= '0;
                    addr_ptr <= ADDR_BITS'(BASE_ADDR);
                end
                ADDR: begin
                    bus.rom_addr <= addr_ptr;
                    wcnt         <= '0;
                end
                WAIT: wcnt <= wcnt + 3'd1;
                PLOT: begin
                    bus.color <= bus.rom_data;
                    if (!skip) begin
                        bus.x      <= x_sum[X_BITS-1:0];
                        bus.y      <= y_sum[Y_BITS-1:0];
                        bus.drawEn <= 1'b1;
                    end
                    // Row-major image: row*W+col advances by exactly one per pixel.
                    addr_ptr <= addr_ptr + ADDR_BITS'(1);
                    if (last_col) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                DONE: begin
                    if (!bus.done)            bus.done <= 1'b1;
                    else if (!bus.begin_draw) bus.done <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_draw_sprite.sv
// Bench for draw_sprite: 4x2 image on a latency-1 and a latency-3 instance, scoreboard of expected pixels.
module tb_draw_sprite;
    localparam int IW = 4;
    localparam int IH = 2;
`ifdef DRAW_SPRITE_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } px_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bd_a = 1'b0;
    logic bd_b = 1'b0;
    int   x0v = 0;
    int   y0v = 0;
    int   ecnt = 0;
    int   total = 0;
    int   bad = 0;
    logic [2:0] mem [0:7];
    logic [2:0] rom_a;
    logic [2:0] p1, p2, p3;
    px_t  q[$];
    px_t  e;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    draw_sprite_if #(.X_BITS(8), .Y_BITS(7), .COLOR_BITS(3), .ADDR_BITS(15)) if_a ();
    draw_sprite_if #(.X_BITS(8), .Y_BITS(7), .COLOR_BITS(3), .ADDR_BITS(15)) if_b ();

    draw_sprite #(.W(IW), .H(IH), .ROM_LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    draw_sprite #(.W(IW), .H(IH), .ROM_LATENCY(3)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));

    assign if_a.begin_draw = bd_a;
    assign if_b.begin_draw = bd_b;
    assign if_a.x0 = x0v[7:0];
    assign if_b.x0 = x0v[7:0];
    assign if_a.y0 = y0v[6:0];
    assign if_b.y0 = y0v[6:0];

    // Synchronous ROMs: one register stage for A, three for B.
    always @(posedge clk) begin
        rom_a <= mem[if_a.rom_addr[2:0]];
        p1    <= mem[if_b.rom_addr[2:0]];
        p2    <= p1;
        p3    <= p2;
    end
    assign if_a.rom_data = rom_a;
    assign if_b.rom_data = p3;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int done_of(input int inst);
        return inst != 0 ? int'(if_b.done) : int'(if_a.done);
    endfunction

    function automatic int busy_of(input int inst);
        return inst != 0 ? int'(if_b.busy) : int'(if_a.busy);
    endfunction

    // n = edge at which begin_draw is accepted; pixel i appears after edge n+2+L+i*(L+2).
    task automatic push_expected(input int lat, input int xo, input int yo, input int n, input int npix);
        for (int i = 0; i < npix; i++) begin
            px_t p;
            int  r, c, xs, ys;
            bit  skip;
            r  = i / IW;
            c  = i % IW;
            xs = xo + c;
            ys = yo + r;
            skip = (xs >= 160) || (ys >= 120) || (TRANSP && mem[i] == 3'd0);
            if (!skip) begin
                p.x = xs;
                p.y = ys;
                p.c = int'(mem[i]);
                p.t = n + 2 + lat + i * (lat + 2);
                q.push_back(p);
            end
        end
    endtask

    always @(negedge clk) begin
        if (if_a.drawEn || if_b.drawEn) begin
            check("single_inst_pulse", int'(if_a.drawEn && if_b.drawEn), 0);
            check("pulse_expected", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("px_x", if_b.drawEn ? int'(if_b.x) : int'(if_a.x), e.x);
                check("px_y", if_b.drawEn ? int'(if_b.y) : int'(if_a.y), e.y);
                check("px_color", if_b.drawEn ? int'(if_b.color) : int'(if_a.color), e.c);
                check("px_time", ecnt, e.t);
            end
        end
    end

    task automatic run_draw(input int inst, input int xo, input int yo, input int hold);
        int lat, n, seen_at;
        lat = (inst != 0) ? 3 : 1;
        x0v = xo;
        y0v = yo;
        n = ecnt + 1;
        push_expected(lat, xo, yo, n, IW * IH);
        if (inst != 0) bd_b = 1'b1; else bd_a = 1'b1;
        @(negedge clk);
        check("busy_after_accept", busy_of(inst), 1);
        x0v = 77;
        y0v = 3;
        seen_at = -1;
        for (int k = 0; k < 400; k++) begin
            if (done_of(inst) != 0) begin
                seen_at = ecnt;
                break;
            end
            @(negedge clk);
        end
        check("done_time", seen_at, n + IW * IH * (lat + 2) + 1);
        check("queue_drained", q.size(), 0);
        check("busy_in_done", busy_of(inst), 0);
        repeat (hold) @(negedge clk);
        check("done_held", done_of(inst), 1);
        if (inst != 0) bd_b = 1'b0; else bd_a = 1'b0;
        @(negedge clk);
        check("done_dropped", done_of(inst), 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 8; i++) mem[i] = 3'(i + 1);
        repeat (3) @(negedge clk);
        check("rst_rom_addr", int'(if_a.rom_addr), 0);
        check("rst_drawEn", int'(if_a.drawEn), 0);
        check("rst_busy", int'(if_a.busy), 0);
        check("rst_done", int'(if_a.done), 0);
        check("rst_xyc", int'({if_a.x, if_a.y, if_a.color}), 0);
        reset = 1'b0;
        @(negedge clk);

        run_draw(0, 10, 20, 100);
        run_draw(0, 158, 20, 2);
        run_draw(1, 10, 20, 2);
        run_draw(0, 255, 0, 2);
        run_draw(0, 100, 119, 2);
        for (int i = 0; i < 8; i++) mem[i] = (i % 2 != 0) ? 3'd5 : 3'd0;
        run_draw(0, 10, 20, 2);
        run_draw(1, 30, 40, 2);

        // Reset lands on the edge that would end the third pixel's WAIT.
        for (int i = 0; i < 8; i++) mem[i] = 3'(i + 1);
        x0v = 10;
        y0v = 20;
        n = ecnt + 1;
        push_expected(1, 10, 20, n, 2);
        bd_a = 1'b1;
        while (ecnt < n + 7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_busy", int'(if_a.busy), 0);
        check("rstmid_drawEn", int'(if_a.drawEn), 0);
        check("rstmid_done", int'(if_a.done), 0);
        check("rstmid_state", int'(dut_a.state), 0);
        check("rstmid_rom_addr", int'(if_a.rom_addr), 0);
        check("rstmid_x", int'(if_a.x), 0);
        reset = 1'b0;
        bd_a = 1'b0;
        repeat (20) @(negedge clk);
        check("rstmid_queue", q.size(), 0);
        check("rstmid_idle_busy", int'(if_a.busy), 0);

        run_draw(0, 0, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/draw_sprite.md
Name: draw_sprite

Overview:
- Parametrised rectangular image blitter. Generalises the full-screen background drawer to any W x H image at a runtime origin (x0, y0).
- Reads pixel colours from an external synchronous ROM with configurable read latency. Streams (x, y, color, drawEn) to the VGA adapter.
- Clips pixels that fall off-screen.
- Uses the same begin_draw/done level handshake as the existing draw blocks, so the game FSM can sequence background and sprites identically.

Parameters:
- W, 160, image width in pixels (>=1)
- H, 120, image height in pixels (>=1)
- SCREEN_W, 160, visible screen width; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 120, visible screen height; pixels with y >= SCREEN_H are clipped
- X_BITS, 8, width of x coordinates
- Y_BITS, 7, width of y coordinates
- COLOR_BITS, 3, colour width
- ADDR_BITS, 15, ROM address width
- BASE_ADDR, 0, ROM address of image pixel (0,0)
- ROM_LATENCY, 1, cycles from rom_addr change to valid rom_data (1..4)
- KEY_COLOR, 3'b000, transparent colour (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- begin_draw  in  1  level request; rising acceptance starts a draw
- x0  in  X_BITS  image origin x, latched at acceptance
- y0  in  Y_BITS  image origin y, latched at acceptance
- rom_addr  out  ADDR_BITS  ROM read address (registered)
- rom_data  in  COLOR_BITS  ROM read data
- x  out  X_BITS  pixel x to VGA adapter
- y  out  Y_BITS  pixel y to VGA adapter
- color  out  COLOR_BITS  pixel colour to VGA adapter
- drawEn  out  1  write strobe, one cycle per written pixel
- busy  out  1  high while drawing
- done  out  1  high from completion until begin_draw drops

Behaviour:
- Reset: clk and reset are the only clock/reset; reset is synchronous, active-high. On reset, state=IDLE, rom_addr=BASE_ADDR, and x, y, color, drawEn, busy, done are all 0. Reset mid-draw aborts immediately, with no further drawEn.
- States: IDLE, ADDR, WAIT, PLOT, DONE.
- IDLE:
  - If begin_draw=1: latch x0/y0, set col=0, row=0, go to ADDR.
  - Else stay in IDLE.
- ADDR:
  - rom_addr <= BASE_ADDR + row*W + col. The product is maintained incrementally; no multiplier.
  - Next state is WAIT.
- WAIT:
  - Stays exactly ROM_LATENCY cycles, tracked by an internal counter.
  - Then go to PLOT.
- PLOT:
  - rom_data is valid in this cycle.
  - On the exiting edge: x <= x0+col, y <= y0+row, color <= rom_data.
  - drawEn <= 1 unless the pixel is clipped; otherwise drawEn <= 0.
  - Advance: col+1; at col=W-1, col=0 and row+1.
  - After the pixel at (W-1, H-1), go to DONE. Otherwise go to ADDR.
- drawEn:
  - Registered. High for exactly the one cycle after PLOT.
  - x, y and color hold their values until the next PLOT exit.
  - drawEn is 0 in every other cycle.
- Timing:
  - Pixel period is ROM_LATENCY+2 cycles.
  - If begin_draw is sampled high in IDLE at edge n, the first drawEn is high in cycle n+3+ROM_LATENCY.
  - Total draw time is W*H*(ROM_LATENCY+2) cycles.
- Clipping:
  - Compute x0+col with X_BITS+1 bits and y0+row with Y_BITS+1 bits.
  - A pixel is clipped if the sum is >= SCREEN_W (or >= SCREEN_H), including carry-out.
  - A clipped pixel keeps its full timing slot but drawEn stays 0; its x/y outputs are not updated.
- busy: 1 in ADDR, WAIT and PLOT; 0 in IDLE and DONE.
- DONE:
  - done=1, registered, asserted the cycle after the final drawEn slot.
  - Stays in DONE while begin_draw=1.
  - When begin_draw=0: done <= 0 and go to IDLE.
  - A new draw requires begin_draw to be low for at least one cycle; a held-high begin_draw never retriggers.
- Inputs: changes to x0/y0 during a draw are ignored.

Optional Feature:
- Macro: DRAW_SPRITE_TRANSPARENT_EN
- When defined: in PLOT, a pixel whose rom_data == KEY_COLOR is treated exactly like a clipped pixel. drawEn stays 0, the timing slot is kept, and the pixel counts toward completion. This allows sprites to be drawn over the background.
- When undefined: KEY_COLOR is ignored and every unclipped pixel is written, including KEY_COLOR pixels.

Test Plan:
- W=4, H=2, ROM_LATENCY=1, x0=10, y0=20, ROM holds 1..8 at BASE_ADDR 0; pulse begin_draw at edge 0 -> 8 drawEn pulses, each 3 cycles apart. The first is at cycle 4 with (10,20,1); the last is (13,21,0 mod 8 -> 3'b000). done rises the cycle after the last pulse.
- Same setup, x0=158 -> only cols 0-1 are written (x=158,159), i.e. 4 drawEn pulses. Total duration is still 24 cycles before done.
- ROM_LATENCY=3, same image -> pixel period 5 cycles. The first drawEn is at cycle 6. Every color matches the ROM contents at the rom_addr issued 3 cycles earlier.
- Hold begin_draw high for 100 cycles after done -> done stays 1 with no retrigger. Drop begin_draw -> done is 0 next cycle; re-raise -> a new draw begins.
- Assert reset during the 3rd pixel's WAIT -> the next cycle has busy=0, drawEn=0, done=0 and state IDLE. No further drawEn pulses.
- With DRAW_SPRITE_TRANSPARENT_EN and ROM = {0,5,0,5,...}, KEY_COLOR=0 -> only odd columns are written (4 pulses, color=5), and completion time is unchanged. Without the macro, 8 pulses are produced.
